hit_dispatcher: RTL

HIT_DISPATCHER -- requirements
Module: hit_dispatcher

---
 rtl/hit_dispatcher_pkg.sv | 37 +++
 rtl/hit_fifo.sv | 61 ++++++
 rtl/hit_dispatcher.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hit_dispatcher_pkg.sv
// Shared definitions for the seed-hit dispatcher: hit record layout,
// block size used to form the hit address, and FSM state encoding.
package hit_dispatcher_pkg;

  localparam int DC_W       = 17;
  localparam int SH_W       = 9;
  localparam int LQ_W       = 9;
  localparam int HIT_W      = DC_W + SH_W + LQ_W;
  localparam int SRC_W      = 3;
  localparam int ADDR_W     = 32;
  localparam int BLOCK_SIZE = 512;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_BUSY   = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

  typedef struct packed {
    logic [DC_W-1:0] dc;
    logic [SH_W-1:0] sh;
    logic [LQ_W-1:0] lq;
  } hit_t;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    hit_t             hit;
  } entry_t;

  // Linear symbol address of a hit; shiftNo is below the block size so
  // the sum never carries into dataCounter bits.
  function automatic logic [ADDR_W-1:0] hit_addr(input hit_t h);
    return ADDR_W'(h.dc) * ADDR_W'(BLOCK_SIZE) + ADDR_W'(h.sh);
  endfunction

endpackage

// File: rtl/hit_fifo.sv
// Hit FIFO: array storage with a registered read port. data_o holds the
// last popped entry and only changes on a pop, so it doubles as the
// dispatcher's hold register.
module hit_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [W-1:0]  rd_data_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // A full FIFO refuses pushes even when a pop happens the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = rd_data_q;

  // Storage write; no reset so the array can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

  // Pointers, occupancy and registered read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem[rd_ptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/hit_dispatcher.sv
// Seed-hit dispatcher: round-robin arbitration of hit requesters into a
// FIFO, then one extension at a time to the expander with duplicate
// suppression against the last reported window and a watchdog.
module hit_dispatcher
  import hit_dispatcher_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*HIT_W-1:0] req_hit,
  output logic                  exp_start,
  output logic [DC_W-1:0]       exp_dataCounter,
  output logic [SH_W-1:0]       exp_shiftNo,
  output logic [LQ_W-1:0]       exp_LocationQ,
  input  logic                  exp_stop,
  input  logic [ADDR_W-1:0]     exp_locationStart,
  input  logic [ADDR_W-1:0]     exp_locationEnd,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ADDR_W-1:0]     res_start,
  output logic [ADDR_W-1:0]     res_end,
  output logic [SRC_W-1:0]      res_src,
  output logic [15:0]           drop_cnt,
  output logic                  err_timeout
);

  localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  hit_t              req_hit_a [NREQ];
  logic [SRC_W-1:0]  rr_q, rr_d;
  logic              run_q;
  logic              push;
  entry_t            push_entry;
  entry_t            head;
  logic              fifo_full, fifo_empty, pop;
  logic              in_window;

  state_e            state_q;
  logic              exp_start_q, res_valid_q, win_valid_q, err_q, first_q;
  logic [ADDR_W-1:0] last_start_q, last_end_q;
  logic [SRC_W-1:0]  res_src_q;
  logic [15:0]       drop_cnt_q;
  logic [WD_W-1:0]   wdog_q;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_hit_a[gi] = req_hit[gi*HIT_W +: HIT_W];
  end

  // Round-robin grant: first valid requester at or after the pointer.
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] sel;
    idx        = 0;
    sel        = '0;
    req_ready  = '0;
    rr_d       = rr_q;
    push       = 1'b0;
    push_entry = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = SEL_W'(idx);
      if (!push && run_q && !fifo_full && req_valid[sel]) begin
        push           = 1'b1;
        req_ready[sel] = 1'b1;
        push_entry     = '{src: SRC_W'(idx), hit: req_hit_a[sel]};
        rr_d           = (idx == NREQ - 1) ? '0 : SRC_W'(idx + 1);
      end
    end
  end

  // Pointer update; run_q keeps req_ready low until reset has been released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q  <= '0;
      run_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      run_q <= 1'b1;
    end
  end

  assign pop = (state_q == ST_IDLE) && !fifo_empty;

  hit_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_window = (hit_addr(head.hit) >= last_start_q) &&
                     (hit_addr(head.hit) <= last_end_q);

  // Dispatch FSM: issue, wait for completion or watchdog, report.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      exp_start_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_src_q    <= '0;
      last_start_q <= '0;
      last_end_q   <= '0;
      win_valid_q  <= 1'b0;
      drop_cnt_q   <= '0;
      err_q        <= 1'b0;
      wdog_q       <= '0;
      first_q      <= 1'b0;
    end else begin
      exp_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (win_valid_q && in_window) begin
            if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
            state_q <= ST_IDLE;
          end else if (!exp_stop) begin
            exp_start_q <= 1'b1;
            wdog_q      <= '0;
            first_q     <= 1'b1;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          first_q <= 1'b0;
          // exp_stop may still reflect the previous extension on the first cycle.
          if (!first_q && exp_stop) begin
            last_start_q <= exp_locationStart;
            last_end_q   <= exp_locationEnd;
            win_valid_q  <= 1'b1;
            res_src_q    <= head.src;
            res_valid_q  <= 1'b1;
            state_q      <= ST_REPORT;
          end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            wdog_q <= wdog_q + WD_W'(1);
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign exp_start       = exp_start_q;
  assign exp_dataCounter = head.hit.dc;
  assign exp_shiftNo     = head.hit.sh;
  assign exp_LocationQ   = head.hit.lq;
  assign res_valid       = res_valid_q;
  assign res_start       = last_start_q;
  assign res_end         = last_end_q;
  assign res_src         = res_src_q;
  assign drop_cnt        = drop_cnt_q;
  assign err_timeout     = err_q;

endmodule
